// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing engine: sync/DE generation, pixel coordinates, built-in
// test patterns and a frame counter; pattern mode is latched only at frame boundaries.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int CHK_LOG2 = 5,
  parameter int FRAME_W  = 16,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [1:0]         i_mode,
  input  logic [COLOR_W-1:0] i_R,
  input  logic [COLOR_W-1:0] i_G,
  input  logic [COLOR_W-1:0] i_B,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_H_sync,
  output logic               o_V_sync,
  output logic               o_de,
  output logic               o_blank_n,
  output logic [COLOR_W-1:0] o_R,
  output logic [COLOR_W-1:0] o_G,
  output logic [COLOR_W-1:0] o_B,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [FRAME_W-1:0] o_frame_cnt
);

  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [X_W-1:0]    H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]    H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]    HS_FIRST = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]    HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0]    V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]    V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]    VS_FIRST = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]    VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

  logic [X_W-1:0]     h;
  logic [Y_W-1:0]     v;
  logic [1:0]         mode;
  logic [FRAME_W-1:0] frame_cnt;
  logic [2:0]         bar_idx;
  logic [BAR_CW-1:0]  bar_px;

  logic               h_wrap;
  logic               frame_wrap;
  logic               active;
  logic               hs_act;
  logic               vs_act;
  logic [X_W-1:0]     x_scroll;
  logic               chk_static;
  logic               chk_scroll;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;

  assign h_wrap     = (h == H_LAST);
  assign frame_wrap = h_wrap && (v == V_LAST);
  assign active     = (h < H_ACT) && (v < V_ACT);
  assign hs_act     = (h >= HS_FIRST) && (h <= HS_LAST);
  assign vs_act     = (v >= VS_FIRST) && (v <= VS_LAST);

  // Scrolling variant offsets x by the frame count, wrapping within the x width.
  assign x_scroll   = h + X_W'(frame_cnt);
  assign chk_static = h[CHK_LOG2] ^ v[CHK_LOG2];
  assign chk_scroll = x_scroll[CHK_LOG2] ^ v[CHK_LOG2];

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (active) begin
      case (mode)
        2'd0: begin
          pix_r = i_R;
          pix_g = i_G;
          pix_b = i_B;
        end
        2'd1: begin
          pix_r = {COLOR_W{~bar_idx[1]}};
          pix_g = {COLOR_W{~bar_idx[2]}};
          pix_b = {COLOR_W{~bar_idx[0]}};
        end
        2'd2: begin
          pix_r = {COLOR_W{~chk_static}};
          pix_g = {COLOR_W{~chk_static}};
          pix_b = {COLOR_W{~chk_static}};
        end
        default: begin
          pix_r = {COLOR_W{~chk_scroll}};
          pix_g = {COLOR_W{~chk_scroll}};
          pix_b = {COLOR_W{~chk_scroll}};
        end
      endcase
    end
  end

  // Bar index advances every BAR_W pixels so no divider is needed on h.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h         <= '0;
      v         <= '0;
      mode      <= 2'd0;
      frame_cnt <= '0;
      bar_idx   <= 3'd0;
      bar_px    <= '0;
    end else if (i_en) begin
      if (h_wrap) begin
        h       <= '0;
        bar_idx <= 3'd0;
        bar_px  <= '0;
        v       <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 1'b1;
        end
      end
      if (frame_wrap) begin
        mode      <= i_mode;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_H_sync      <= ~HS_POL;
      o_V_sync      <= ~VS_POL;
      o_de          <= 1'b0;
      o_blank_n     <= 1'b0;
      o_R           <= '0;
      o_G           <= '0;
      o_B           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_en) begin
      o_H_sync      <= hs_act ? HS_POL : ~HS_POL;
      o_V_sync      <= vs_act ? VS_POL : ~VS_POL;
      o_de          <= active;
      o_blank_n     <= active;
      o_R           <= pix_r;
      o_G           <= pix_g;
      o_B           <= pix_b;
      o_line_start  <= (h == '0);
      o_frame_start <= (h == '0) && (v == '0);
    end
  end

  assign o_x         = h;
  assign o_y         = v;
  assign o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, mid-size and tiny parameter sets
// exercising sync timing, patterns, mode latching, enable gating and async reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- default 640x480 instance ----------------
  logic       rst_d, en_d;
  logic [1:0] mode_d;
  logic [7:0] r_d, g_d, b_d;
  logic [9:0] x_d, y_d;
  logic       hs_d, vs_d, de_d, bl_d, ls_d, fs_d;
  logic [7:0] or_d, og_d, ob_d;
  logic [15:0] fc_d;

  vga_timing_gen dut_d (
    .i_clk(clk), .i_rst(rst_d), .i_en(en_d), .i_mode(mode_d),
    .i_R(r_d), .i_G(g_d), .i_B(b_d),
    .o_x(x_d), .o_y(y_d), .o_H_sync(hs_d), .o_V_sync(vs_d),
    .o_de(de_d), .o_blank_n(bl_d), .o_R(or_d), .o_G(og_d), .o_B(ob_d),
    .o_line_start(ls_d), .o_frame_start(fs_d), .o_frame_cnt(fc_d)
  );

  // ---------------- mid-size instance: 80x48 totals ----------------
  logic       rst_m, en_m;
  logic [1:0] mode_m;
  logic [7:0] r_m, g_m, b_m;
  logic [6:0] x_m;
  logic [5:0] y_m;
  logic       hs_m, vs_m, de_m, bl_m, ls_m, fs_m;
  logic [7:0] or_m, og_m, ob_m;
  logic [15:0] fc_m;
  logic [63:0] pack_m;

  assign r_m = 8'(x_m);
  assign g_m = 8'(y_m);
  assign b_m = 8'h5A;
  assign pack_m = {5'd0, x_m, y_m, hs_m, vs_m, de_m, bl_m, or_m, og_m, ob_m, ls_m, fs_m, fc_m};

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3)
  ) dut_m (
    .i_clk(clk), .i_rst(rst_m), .i_en(en_m), .i_mode(mode_m),
    .i_R(r_m), .i_G(g_m), .i_B(b_m),
    .o_x(x_m), .o_y(y_m), .o_H_sync(hs_m), .o_V_sync(vs_m),
    .o_de(de_m), .o_blank_n(bl_m), .o_R(or_m), .o_G(og_m), .o_B(ob_m),
    .o_line_start(ls_m), .o_frame_start(fs_m), .o_frame_cnt(fc_m)
  );

  // ---------------- tiny instance: 12x7 totals ----------------
  logic       rst_s, en_s;
  logic [1:0] mode_s;
  logic [7:0] r_s, g_s, b_s;
  logic [3:0] x_s;
  logic [2:0] y_s;
  logic       hs_s, vs_s, de_s, bl_s, ls_s, fs_s;
  logic [7:0] or_s, og_s, ob_s;
  logic [1:0] fc_s;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .FRAME_W(2), .CHK_LOG2(1)
  ) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_en(en_s), .i_mode(mode_s),
    .i_R(r_s), .i_G(g_s), .i_B(b_s),
    .o_x(x_s), .o_y(y_s), .o_H_sync(hs_s), .o_V_sync(vs_s),
    .o_de(de_s), .o_blank_n(bl_s), .o_R(or_s), .o_G(og_s), .o_B(ob_s),
    .o_line_start(ls_s), .o_frame_start(fs_s), .o_frame_cnt(fc_s)
  );

  int jm = -1;
  int js = -1;
  int vs_low_m = 0;

  task automatic adv_m(input int target);
    while (jm < target) begin
      @(negedge clk);
      jm++;
      if (vs_m == 1'b0) vs_low_m++;
    end
  endtask

  task automatic adv_s(input int target);
    while (js < target) begin
      @(negedge clk);
      js++;
    end
  endtask

  int ls0, ls1, fall0, fall1, hs_low, last_ls, found, lc0, lc1;
  logic prev_hs;
  logic [63:0] snap;

  initial begin
    rst_d = 1'b0; rst_m = 1'b0; rst_s = 1'b0;
    en_d = 1'b1; en_m = 1'b1; en_s = 1'b1;
    mode_d = 2'd0; mode_m = 2'd0; mode_s = 2'd3;
    r_d = 8'hA5; g_d = 8'h3C; b_d = 8'h0F;
    r_s = 8'h11; g_s = 8'h22; b_s = 8'h33;
    #1;
    rst_d = 1'b1; rst_m = 1'b1; rst_s = 1'b1;
    @(negedge clk);
    @(negedge clk);

    chk("rst_d_hs", int'(hs_d), 1);
    chk("rst_d_vs", int'(vs_d), 1);
    chk("rst_d_de", int'({de_d, bl_d}), 0);
    chk("rst_d_rgb", int'({or_d, og_d, ob_d}), 0);
    chk("rst_d_xy", int'({x_d, y_d}), 0);
    chk("rst_s_hs", int'(hs_s), 0);
    chk("rst_m_fc", int'(fc_m), 0);

    // ---- default instance: line timing ----
    rst_d = 1'b0;
    ls0 = -1; ls1 = -1; fall0 = -1; fall1 = -1; hs_low = 0; last_ls = 0; prev_hs = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      if (ls_d) begin
        if (ls0 < 0) ls0 = k;
        else if (ls1 < 0) ls1 = k;
        last_ls = k;
      end
      if (prev_hs && !hs_d) begin
        if (fall0 < 0) fall0 = k - last_ls;
        else if (fall1 < 0) fall1 = k - last_ls;
      end
      if (k < 800 && !hs_d) hs_low++;
      prev_hs = hs_d;
      if (k == 0) begin
        chk("d_first_fs", int'(fs_d), 1);
        chk("d_first_de", int'(de_d), 1);
      end
      if (k == 639) chk("d_de_last", int'(de_d), 1);
      if (k == 640) begin
        chk("d_de_off", int'({de_d, bl_d}), 0);
        chk("d_rgb_off", int'({or_d, og_d, ob_d}), 0);
      end
    end
    chk("d_ls_first", ls0, 0);
    chk("d_line_period", ls1 - ls0, 800);
    chk("d_hs_fall0", fall0, 656);
    chk("d_hs_fall1", fall1, 656);
    chk("d_hs_low", hs_low, 96);

    // ---- default instance: async reset mid-line at h=300, v=10 ----
    for (int k = 1600; k < 8300; k++) @(negedge clk);
    chk("d_pre_x", int'(x_d), 300);
    chk("d_pre_y", int'(y_d), 10);
    chk("d_pre_rgb", int'({or_d, og_d, ob_d}), 'hA53C0F);
    #2 rst_d = 1'b1;
    #1;
    chk("d_arst_xy", int'({x_d, y_d}), 0);
    chk("d_arst_sync", int'({hs_d, vs_d}), 3);
    chk("d_arst_de", int'({de_d, bl_d, ls_d, fs_d}), 0);
    chk("d_arst_rgb", int'({or_d, og_d, ob_d}), 0);
    chk("d_arst_fc", int'(fc_d), 0);
    @(negedge clk);
    rst_d = 1'b0;
    @(negedge clk);
    chk("d_rel_fs", int'(fs_d), 1);
    chk("d_rel_de", int'(de_d), 1);
    chk("d_rel_x", int'(x_d), 1);

    // ---- mid instance: external mode, frame count, vsync ----
    rst_m = 1'b0;
    adv_m(0);
    chk("m_fs0", int'(fs_m), 1);
    chk("m_de0", int'({de_m, bl_m}), 3);
    chk("m_ext0", int'({or_m, og_m, ob_m}), 'h00005A);
    adv_m(5);
    chk("m_ext5", int'(or_m), 5);
    chk("m_fs5", int'(fs_m), 0);
    adv_m(64);
    chk("m_blank64", int'({de_m, or_m, og_m, ob_m}), 0);
    adv_m(250);
    chk("m_ext_10_3", int'({or_m, og_m}), 'h0A03);
    mode_m = 2'd1;
    adv_m(3838);
    chk("m_fc_pre", int'(fc_m), 0);
    adv_m(3839);
    chk("m_fc_1", int'(fc_m), 1);
    chk("m_fs_last", int'(fs_m), 0);
    chk("m_vs_low", vs_low_m, 240);

    // ---- colour bars ----
    adv_m(3840);
    chk("m_fs_f1", int'(fs_m), 1);
    chk("m_bar_white", int'({or_m, og_m, ob_m}), 'hFFFFFF);
    adv_m(3847);
    chk("m_bar_x7", int'({or_m, og_m, ob_m}), 'hFFFFFF);
    adv_m(3848);
    chk("m_bar_yellow", int'({or_m, og_m, ob_m}), 'hFFFF00);
    adv_m(3856);
    chk("m_bar_cyan", int'({or_m, og_m, ob_m}), 'h00FFFF);
    adv_m(3872);
    chk("m_bar_magenta", int'({or_m, og_m, ob_m}), 'hFF00FF);
    adv_m(3896);
    chk("m_bar_black", int'({de_m, or_m, og_m, ob_m}), 'h1000000);
    adv_m(3904);
    chk("m_bar_off", int'({de_m, or_m, og_m, ob_m}), 0);
    adv_m(4640);
    mode_m = 2'd2;
    adv_m(5448);
    chk("m_bar_after_sw", int'({or_m, og_m, ob_m}), 'hFFFF00);

    // ---- checkerboard after the frame boundary ----
    adv_m(7680);
    chk("m_chk_0_0", int'({or_m, og_m, ob_m}), 'hFFFFFF);
    chk("m_fc_2", int'(fc_m), 2);
    mode_m = 2'd3;
    adv_m(7712);
    chk("m_chk_32_0", int'({or_m, og_m, ob_m}), 0);
    adv_m(10240);
    chk("m_chk_0_32", int'({or_m, og_m, ob_m}), 0);
    adv_m(10272);
    chk("m_chk_32_32", int'({or_m, og_m, ob_m}), 'hFFFFFF);

    // ---- scrolling checkerboard, frame count 3 ----
    adv_m(11520);
    chk("m_fc_3", int'(fc_m), 3);
    chk("m_scr_0", int'({or_m, og_m, ob_m}), 'hFFFFFF);
    adv_m(11548);
    chk("m_scr_28", int'({or_m, og_m, ob_m}), 'hFFFFFF);
    adv_m(11549);
    chk("m_scr_29", int'({or_m, og_m, ob_m}), 0);

    // ---- 1-of-2 enable duty ----
    snap = pack_m; lc0 = -1; lc1 = -1;
    for (int c = 0; c < 400; c++) begin
      en_m = c[0];
      @(negedge clk);
      if (!en_m) begin
        total++;
        assert (pack_m === snap) else begin
          bad++;
          $error("FAIL m_en_hold: observed=%h expected=%h", pack_m, snap);
        end
      end else if (ls_m) begin
        if (lc0 < 0) lc0 = c;
        else if (lc1 < 0) lc1 = c;
      end
      snap = pack_m;
    end
    en_m = 1'b1;
    chk("m_en_line_period", lc1 - lc0, 160);

    // ---- mid instance async reset with nonzero frame count ----
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (x_m == 7'd30) found = 1;
    end
    chk("m_wait_x30", found, 1);
    chk("m_fc_before", int'(fc_m), 3);
    #2 rst_m = 1'b1;
    #1;
    chk("m_arst_fc", int'(fc_m), 0);
    chk("m_arst_x", int'(x_m), 0);
    chk("m_arst_out", int'({hs_m, vs_m, de_m, bl_m, ls_m, fs_m}), 'h30);
    @(negedge clk);
    rst_m = 1'b0;
    @(negedge clk);
    chk("m_rel_fs", int'(fs_m), 1);

    // ---- tiny instance ----
    rst_s = 1'b0;
    adv_s(0);
    chk("s_ls0", int'({ls_s, fs_s}), 3);
    chk("s_ext0", int'(or_s), 'h11);
    chk("s_hs0", int'(hs_s), 0);
    adv_s(8);
    chk("s_hs8", int'({hs_s, de_s}), 0);
    adv_s(9);
    chk("s_hs9", int'(hs_s), 1);
    adv_s(10);
    chk("s_hs10", int'(hs_s), 1);
    adv_s(11);
    chk("s_hs11", int'({hs_s, ls_s}), 0);
    adv_s(12);
    chk("s_ls12", int'(ls_s), 1);
    adv_s(59);
    chk("s_vs59", int'(vs_s), 1);
    adv_s(60);
    chk("s_vs60", int'(vs_s), 0);
    adv_s(83);
    chk("s_fc1", int'(fc_s), 1);
    adv_s(84);
    chk("s_f1_x0", int'({fs_s, or_s, og_s, ob_s}), 'h1FFFFFF);
    adv_s(85);
    chk("s_f1_x1", int'({or_s, og_s, ob_s}), 0);
    adv_s(87);
    chk("s_f1_x3", int'({or_s, og_s, ob_s}), 'hFFFFFF);
    adv_s(108);
    chk("s_f1_y2", int'({or_s, og_s, ob_s}), 0);
    adv_s(168);
    chk("s_f2_x0", int'({or_s, og_s, ob_s}), 0);
    adv_s(170);
    chk("s_f2_x2", int'({or_s, og_s, ob_s}), 'hFFFFFF);
    adv_s(334);
    chk("s_fc3", int'(fc_s), 3);
    adv_s(335);
    chk("s_fc_wrap", int'(fc_s), 0);
    adv_s(336);
    chk("s_f4_x0", int'({or_s, og_s, ob_s}), 'hFFFFFF);
    adv_s(338);
    chk("s_f4_x2", int'({or_s, og_s, ob_s}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
